adaptive_filter_driver: RTL and testbench
=========================================

// Module: adaptive_filter_driver
// PURPOSE
//  Source side of adaptive_filter: buffers an input sample stream in a FIFO and presents one sample
//  per clk on f_tdata, the filter's free-running input. Owns f_ctrl. A mode change is preceded by a
//  zero-flush of FLUSH_LEN samples so the filter delay line and feedback loop are cleared first.
//  Sits between the upstream sample source and adaptive_filter.
// PARAMETERS
//  DATA_WIDTH  14  sample width, two's complement; must match adaptive_filter
//  FIFO_DEPTH  8   input FIFO entries, power of 2, >=2
//  FLUSH_LEN   8   zero samples sent before a mode switch; >= filter order + feedback delay (2)
// PORTS
//  clk             in   1           clock
//  srst            in   1           synchronous reset, active-high
//  s_tvalid        in   1           upstream sample valid
//  s_tready        out  1           FIFO can accept a sample
//  s_tdata         in   DATA_WIDTH  upstream sample
//  mode_req_valid  in   1           mode change request
//  mode_req_ready  out  1           request accepted when valid&&ready
//  mode_req        in   1           requested mode: 1 integrator, 0 differentiator
//  mode_done       out  1           1-cycle pulse when the requested mode is in effect
//  f_tdata         out  DATA_WIDTH  sample to filter s_tdata, registered
//  f_dvalid        out  1           f_tdata carries a FIFO sample (0 = fill/flush zero)
//  f_ctrl          out  1           filter mode to filter ctrl, registered
//  underflow       out  1           sticky: FIFO was empty during RUN
//  clr_underflow   in   1           clears underflow
// BEHAVIOUR
//  Reset: f_tdata=0, f_dvalid=0, f_ctrl=0, mode_done=0, underflow=0, FIFO empty, state RUN,
//   flush counter 0, pending mode discarded. Reset mid-flush aborts the flush; f_ctrl returns to 0.
//  FIFO: s_tready = (count < FIFO_DEPTH), from registered count; write on s_tvalid&&s_tready.
//   When full, no write is accepted even if a pop happens in the same cycle.
//   Simultaneous push and pop when not full: count unchanged.
//   Pointers wrap modulo FIFO_DEPTH.
//  Latency: a sample accepted at edge N with FIFO empty and state RUN appears on f_tdata after edge N+1
//   with f_dvalid=1. Order is strictly FIFO; no sample is dropped or duplicated.
//  Every cycle f_tdata updates:
//   - RUN, FIFO non-empty: pop; f_tdata <= head; f_dvalid <= 1.
//   - RUN, FIFO empty: f_tdata <= 0; f_dvalid <= 0; underflow <= 1.
//   - FLUSH / SWITCH: no pop; f_tdata <= 0; f_dvalid <= 0; underflow unaffected.
//  Underflow: set has priority over clr_underflow in the same cycle.
//  Mode FSM (mode_req_ready = state==RUN):
//   - RUN: if handshake and mode_req==f_ctrl, pulse mode_done next cycle and stay in RUN.
//     If mode_req!=f_ctrl, latch pending mode, load cnt=FLUSH_LEN-1 and go to FLUSH.
//   - FLUSH: zeros out; cnt decrements; when cnt==0 go to SWITCH. Total FLUSH_LEN zero cycles.
//   - SWITCH: one cycle, f_ctrl <= pending, zero out, mode_done <= 1, go to RUN.
//  The FIFO continues to accept input during FLUSH/SWITCH until full (upstream backpressure).
//  Requests presented outside RUN are not accepted (ready=0) and must be held by the requester.
// TESTING
//  1. Reset, ctrl default: after srst, f_ctrl=0, f_tdata=0, s_tready=1, underflow=0.
//  2. Streaming: push 1,2,3,... every cycle -> f_tdata shows 1,2,3 from edge N+1, f_dvalid=1, no gaps.
//  3. Full/backpressure: hold off pops via flush, push 8 samples -> s_tready=0 at count 8;
//     9th is held, not lost.
//  4. Mode switch: req mode_req=1 in RUN -> exactly 8 zero cycles, then 1 SWITCH zero cycle,
//     f_ctrl=1, single mode_done, FIFO data resumes in order.
//  5. Same-mode request with f_ctrl=0, req=0 -> no flush, mode_done the next cycle, stream uninterrupted.
//  6. Underflow and reset: empty FIFO in RUN -> underflow=1 and f_tdata=0. With set and
//     clr_underflow in the same cycle, underflow stays 1. srst mid-FLUSH -> RUN, f_ctrl=0, FIFO empty.

Source files
------------

// File: rtl/adaptive_filter_driver_if.sv
// Sample-source bundle between adaptive_filter_driver (master) and its surroundings (slave).
interface adaptive_filter_driver_if #(
    parameter int DATA_WIDTH = 14
);
    logic                  s_tvalid;
    logic                  s_tready;
    logic [DATA_WIDTH-1:0] s_tdata;
    logic                  mode_req_valid;
    logic                  mode_req_ready;
    logic                  mode_req;
    logic                  mode_done;
    logic [DATA_WIDTH-1:0] f_tdata;
    logic                  f_dvalid;
    logic                  f_ctrl;
    logic                  underflow;
    logic                  clr_underflow;

    modport master (
        input  s_tvalid, s_tdata, mode_req_valid, mode_req, clr_underflow,
        output s_tready, mode_req_ready, mode_done, f_tdata, f_dvalid, f_ctrl, underflow
    );

    modport slave (
        output s_tvalid, s_tdata, mode_req_valid, mode_req, clr_underflow,
        input  s_tready, mode_req_ready, mode_done, f_tdata, f_dvalid, f_ctrl, underflow
    );
endinterface

// File: rtl/adaptive_filter_driver.sv
// FIFO-buffered source feeding one sample per clk to adaptive_filter; mode changes zero-flush first.
// Empty FIFO -> 1 cycle sample latency; s_tready drops at FIFO full, mode requests stall outside RUN.
module adaptive_filter_driver #(
    parameter int DATA_WIDTH = 14,
    parameter int FIFO_DEPTH = 8,
    parameter int FLUSH_LEN  = 8
) (
    input  logic                  clk,
    input  logic                  srst,
    adaptive_filter_driver_if.master bus
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = $clog2(FLUSH_LEN + 1);
    localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

    typedef enum logic [1:0] {RUN, FLUSH, SWITCH} state_t;

    state_t                state;
    logic [CNTW-1:0]       flush_cnt;
    logic                  pending;
    logic                  f_ctrl_q;
    logic                  mode_done_q;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic [DATA_WIDTH-1:0] f_tdata_q;
    logic                  f_dvalid_q;
    logic                  underflow_q;

    logic                  push;
    logic                  pop;
    logic                  empty;
    logic                  req_fire;

    // Ready comes from the registered count only, so a full FIFO refuses a write even while popping.
    assign bus.s_tready       = (count < DEPTH_C);
    assign bus.mode_req_ready = (state == RUN);
    assign empty              = (count == '0);
    assign push               = bus.s_tvalid && bus.s_tready;
    assign pop                = (state == RUN) && !empty;
    assign req_fire           = bus.mode_req_valid && bus.mode_req_ready;

    assign bus.f_tdata   = f_tdata_q;
    assign bus.f_dvalid  = f_dvalid_q;
    assign bus.f_ctrl    = f_ctrl_q;
    assign bus.mode_done = mode_done_q;
    assign bus.underflow = underflow_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.s_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            f_tdata_q   <= '0;
            f_dvalid_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (pop) begin
                f_tdata_q  <= mem[rd_ptr];
                f_dvalid_q <= 1'b1;
            end else begin
                f_tdata_q  <= '0;
                f_dvalid_q <= 1'b0;
            end
            // A fresh underflow wins over a clear issued in the same cycle.
            if (state == RUN && empty) begin
                underflow_q <= 1'b1;
            end else if (bus.clr_underflow) begin
                underflow_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state       <= RUN;
            flush_cnt   <= '0;
            pending     <= 1'b0;
            f_ctrl_q    <= 1'b0;
            mode_done_q <= 1'b0;
        end else begin
            mode_done_q <= 1'b0;
            case (state)
                RUN: begin
                    if (req_fire) begin
                        if (bus.mode_req == f_ctrl_q) begin
                            mode_done_q <= 1'b1;
                        end else begin
                            pending   <= bus.mode_req;
                            flush_cnt <= CNTW'(FLUSH_LEN - 1);
                            state     <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_cnt == '0) begin
                        state <= SWITCH;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                SWITCH: begin
                    f_ctrl_q    <= pending;
                    mode_done_q <= 1'b1;
                    state       <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_adaptive_filter_driver.sv
// Directed vector table plus hand sequences for mode switching and reset during flush.
module tb_adaptive_filter_driver;
    localparam int DW = 14;

    logic clk  = 1'b0;
    logic srst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    adaptive_filter_driver_if #(.DATA_WIDTH(DW)) bus ();

    adaptive_filter_driver #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(8),
        .FLUSH_LEN (8)
    ) dut (
        .clk (clk),
        .srst(srst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          tv;
        logic [DW-1:0] td;
        logic          mv;
        logic          mr;
        logic          clr;
        logic [DW-1:0] e_d;
        logic          e_dv;
        logic          e_ctrl;
        logic          e_md;
        logic          e_uf;
        logic          e_tr;
        logic          e_mrdy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic tv, input int td, input logic mv, input logic mr, input logic clr,
                       input int e_d, input logic e_dv, input logic e_ctrl, input logic e_md,
                       input logic e_uf, input logic e_tr, input logic e_mrdy);
        vec_t v;
        v.tv = tv; v.td = DW'(td); v.mv = mv; v.mr = mr; v.clr = clr;
        v.e_d = DW'(e_d); v.e_dv = e_dv; v.e_ctrl = e_ctrl; v.e_md = e_md;
        v.e_uf = e_uf; v.e_tr = e_tr; v.e_mrdy = e_mrdy;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic tv, input int td, input logic mv, input logic mr, input logic clr);
        bus.s_tvalid       = tv;
        bus.s_tdata        = DW'(td);
        bus.mode_req_valid = mv;
        bus.mode_req       = mr;
        bus.clr_underflow  = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int idx, input int d, input logic dv, input logic ctrl,
                           input logic md, input logic uf, input logic tr, input logic mrdy);
        chk({tag, ".f_tdata"},        idx, 32'(bus.f_tdata), 32'(d));
        chk({tag, ".f_dvalid"},       idx, 32'(bus.f_dvalid), 32'(dv));
        chk({tag, ".f_ctrl"},         idx, 32'(bus.f_ctrl), 32'(ctrl));
        chk({tag, ".mode_done"},      idx, 32'(bus.mode_done), 32'(md));
        chk({tag, ".underflow"},      idx, 32'(bus.underflow), 32'(uf));
        chk({tag, ".s_tready"},       idx, 32'(bus.s_tready), 32'(tr));
        chk({tag, ".mode_req_ready"}, idx, 32'(bus.mode_req_ready), 32'(mrdy));
    endtask

    initial begin
        int n;
        logic saw_data;

        // Streaming, same-mode request, underflow set-vs-clear, full FIFO during flush, switch to mode 1.
        add(1, 1, 0, 0, 0,   0, 0, 0, 0, 1, 1, 1);
        add(1, 2, 0, 0, 1,   1, 1, 0, 0, 0, 1, 1);
        add(1, 3, 0, 0, 0,   2, 1, 0, 0, 0, 1, 1);
        add(1, 4, 1, 0, 0,   3, 1, 0, 1, 0, 1, 1);
        add(1, 5, 0, 0, 0,   4, 1, 0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 0,   5, 1, 0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 1,   0, 0, 0, 0, 1, 1, 1);
        add(1, 6, 0, 0, 0,   0, 0, 0, 0, 1, 1, 1);
        add(1, 7, 0, 0, 1,   6, 1, 0, 0, 0, 1, 1);
        add(1, 8, 1, 1, 0,   7, 1, 0, 0, 0, 1, 0);
        for (int k = 9; k <= 14; k++) add(1, k, 0, 0, 0,   0, 0, 0, 0, 0, 1, 0);
        add(1, 15, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        add(1, 16, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        add(1, 16, 0, 0, 0,  0, 0, 1, 1, 0, 0, 1);
        add(1, 16, 0, 0, 0,  8, 1, 1, 0, 0, 1, 1);
        add(1, 16, 0, 0, 0,  9, 1, 1, 0, 0, 1, 1);
        for (int k = 10; k <= 16; k++) add(0, 0, 0, 0, 0,   k, 1, 1, 0, 0, 1, 1);
        add(0, 0, 0, 0, 0,   0, 0, 1, 0, 1, 1, 1);

        drive(0, 0, 0, 0, 0);
        srst = 1'b1;
        tick();
        tick();
        chk_all("reset", 0, 0, 0, 0, 0, 0, 1, 1);
        srst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].tv, int'(vecs[i].td), vecs[i].mv, vecs[i].mr, vecs[i].clr);
            tick();
            chk_all("vec", i, int'(vecs[i].e_d), vecs[i].e_dv, vecs[i].e_ctrl, vecs[i].e_md,
                    vecs[i].e_uf, vecs[i].e_tr, vecs[i].e_mrdy);
        end

        // Switch back to mode 0: count zero cycles until mode_done, bounded.
        drive(1, 100, 1, 0, 0);
        tick();
        chk("sw0.ready_low", 0, 32'(bus.mode_req_ready), 32'd0);
        drive(0, 0, 0, 0, 0);
        n = 0;
        saw_data = 1'b0;
        while (n < 20) begin
            tick();
            n++;
            if (bus.f_dvalid) saw_data = 1'b1;
            if (bus.mode_done) break;
        end
        chk("sw0.zero_cycles", 0, 32'(n), 32'd9);
        chk("sw0.no_data", 0, 32'(saw_data), 32'd0);
        chk("sw0.f_ctrl", 0, 32'(bus.f_ctrl), 32'd0);
        tick();
        chk("sw0.done_pulse", 0, 32'(bus.mode_done), 32'd0);
        chk("sw0.resume_data", 0, 32'(bus.f_tdata), 32'd100);
        chk("sw0.resume_dv", 0, 32'(bus.f_dvalid), 32'd1);

        // Reset in the middle of a flush toward mode 1.
        drive(1, 200, 1, 1, 0);
        tick();
        drive(1, 201, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();
        chk("rstflush.in_flush", 0, 32'(bus.mode_req_ready), 32'd0);
        srst = 1'b1;
        tick();
        chk_all("rstflush", 1, 0, 0, 0, 0, 0, 1, 1);
        srst = 1'b0;
        tick();
        chk_all("rstflush", 2, 0, 0, 0, 0, 1, 1, 1);
        tick();
        chk("rstflush.no_switch", 3, 32'(bus.f_ctrl), 32'd0);
        chk("rstflush.no_done", 3, 32'(bus.mode_done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
